// File: rtl/store_lane_packer.sv
// store_lane_packer
//
// Purpose:
//   Packs an SB/SH/SW store request into the byte lanes of a word-aligned memory
//   write and generates the matching byte strobes. A misaligned store that
//   crosses a word boundary is split into two back-to-back memory beats.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   store request handshake (ready only while IDLE)
//   req_addr/data/size    byte address, register data, size (00 B, 01 H, 10 W, 11 illegal)
//   mem_valid/mem_ready   memory write beat handshake
//   mem_addr/wdata/wstrb  word-aligned address, lane-packed data, byte strobes
//   done                  one-cycle pulse once the last beat is accepted
//   err_size              one-cycle pulse when an illegal-size request is dropped
//   dbg_state             current FSM state (IDLE=0, BEAT0=1, BEAT1=2)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Once mem_valid is raised it stays high, and mem_addr,
// mem_wdata and mem_wstrb stay stable, until mem_ready is seen. All outputs
// are registered.

module store_lane_packer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err_size,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    // Upper half of the shifted data/strobe, replayed as the second beat.
    logic [31:0] hi_data_q, hi_data_d;
    logic [3:0]  hi_strb_q, hi_strb_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Request-side lane packing, used only at acceptance.
    logic [31:0] masked;
    logic [3:0]  basemask;
    logic [63:0] wide;
    logic [7:0]  strb8;

    always_comb begin
        masked   = req_data;
        basemask = 4'b1111;
        case (req_size)
            2'b00: begin
                masked   = {24'b0, req_data[7:0]};
                basemask = 4'b0001;
            end
            2'b01: begin
                masked   = {16'b0, req_data[15:0]};
                basemask = 4'b0011;
            end
            default: begin
                masked   = req_data;
                basemask = 4'b1111;
            end
        endcase
        wide  = {32'b0, masked} << {req_addr[1:0], 3'b000};
        strb8 = {4'b0, basemask} << req_addr[1:0];
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        hi_data_d   = hi_data_q;
        hi_strb_d   = hi_strb_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_size == 2'b11) begin
                        // Illegal size: drop the request, no memory traffic.
                        err_d = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = wide[31:0];
                        mem_wstrb_d = strb8[3:0];
                        hi_data_d   = wide[63:32];
                        hi_strb_d   = strb8[7:4];
                    end
                end
            end
            BEAT0: begin
                if (mem_valid_q && mem_ready) begin
                    if (hi_strb_q != 4'b0000) begin
                        // Word-crossing store: second beat follows with no bubble.
                        // The address add wraps naturally at 2^32.
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_wdata_d = hi_data_q;
                        mem_wstrb_d = hi_strb_q;
                    end else begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_valid_q && mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'b0;
            mem_wdata_q <= 32'b0;
            mem_wstrb_q <= 4'b0;
            hi_data_q   <= 32'b0;
            hi_strb_q   <= 4'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            hi_data_q   <= hi_data_d;
            hi_strb_q   <= hi_strb_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign done      = done_q;
    assign err_size  = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_lane_packer.sv
module tb_store_lane_packer;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err_size;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  store_lane_packer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .done      (done),
    .err_size  (err_size),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance one cycle; sample and drive 1 time unit after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    chk({tag, ".valid"}, {31'b0, mem_valid}, 32'd1);
    chk({tag, ".addr"},  mem_addr, a);
    chk({tag, ".wdata"}, mem_wdata, d);
    chk({tag, ".wstrb"}, {28'b0, mem_wstrb}, {28'b0, s});
  endtask

  task automatic chk_done(input string tag);
    chk({tag, ".done"},  {31'b0, done}, 32'd1);
    chk({tag, ".idle_valid"}, {31'b0, mem_valid}, 32'd0);
    chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  // driver
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_0000;
    req_data  = 32'h5555_AAAA;
    req_size  = 2'b10;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    idle_req();

    // reset state
    step();
    step();
    chk("rst.valid", {31'b0, mem_valid}, 32'd0);
    chk("rst.done",  {31'b0, done}, 32'd0);
    chk("rst.err",   {31'b0, err_size}, 32'd0);
    chk("rst.addr",  mem_addr, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst.ready", {31'b0, req_ready}, 32'd1);
    chk("rst.state", {30'b0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    step();

    // SB at offset 3: single beat
    send(32'h0000_1003, 32'h1234_56AB, 2'b00);
    step();
    idle_req();
    // garbage on req_* after acceptance must not matter
    req_data = 32'hFFFF_FFFF;
    chk_beat("sb3", 32'h0000_1000, 32'hAB00_0000, 4'b1000);
    chk("sb3.ready_busy", {31'b0, req_ready}, 32'd0);
    step();
    chk_done("sb3");
    // new request accepted in the done cycle: SH at offset 3, split
    send(32'h0000_2003, 32'hFFFF_BEEF, 2'b01);
    step();
    idle_req();
    chk("sb3.done_clear", {31'b0, done}, 32'd0);
    chk_beat("sh3.b0", 32'h0000_2000, 32'hEF00_0000, 4'b1000);
    step();
    chk_beat("sh3.b1", 32'h0000_2004, 32'h0000_00BE, 4'b0001);
    chk("sh3.no_early_done", {31'b0, done}, 32'd0);
    chk("sh3.state", {30'b0, dbg_state}, 32'd2);
    step();
    chk_done("sh3");
    step();
    chk("sh3.single_done", {31'b0, done}, 32'd0);

    // SH at offset 2: single beat
    send(32'h0000_7002, 32'h1234_ABCD, 2'b01);
    step();
    idle_req();
    chk_beat("sh2", 32'h0000_7000, 32'hABCD_0000, 4'b1100);
    step();
    chk_done("sh2");
    step();

    // SW at offset 2 with 3 cycles of backpressure on beat0
    mem_ready = 1'b0;
    send(32'h0000_3002, 32'hDEAD_BEEF, 2'b10);
    step();
    idle_req();
    chk_beat("sw2.b0.c0", 32'h0000_3000, 32'hBEEF_0000, 4'b1100);
    step();
    chk_beat("sw2.b0.c1", 32'h0000_3000, 32'hBEEF_0000, 4'b1100);
    step();
    chk_beat("sw2.b0.c2", 32'h0000_3000, 32'hBEEF_0000, 4'b1100);
    step();
    chk_beat("sw2.b0.c3", 32'h0000_3000, 32'hBEEF_0000, 4'b1100);
    chk("sw2.stall_done", {31'b0, done}, 32'd0);
    mem_ready = 1'b1;
    step();
    chk_beat("sw2.b1", 32'h0000_3004, 32'h0000_DEAD, 4'b0011);
    step();
    chk_done("sw2");
    step();

    // SW at the top of the address space: second beat wraps to 0
    send(32'hFFFF_FFFD, 32'h1122_3344, 2'b10);
    step();
    idle_req();
    chk_beat("swwrap.b0", 32'hFFFF_FFFC, 32'h2233_4400, 4'b1110);
    step();
    chk_beat("swwrap.b1", 32'h0000_0000, 32'h0000_0011, 4'b0001);
    step();
    chk_done("swwrap");
    step();

    // illegal size dropped, then back-to-back aligned SW
    send(32'h0000_4000, 32'h0BAD_0BAD, 2'b11);
    step();
    chk("err.pulse", {31'b0, err_size}, 32'd1);
    chk("err.no_beat", {31'b0, mem_valid}, 32'd0);
    chk("err.ready", {31'b0, req_ready}, 32'd1);
    send(32'h0000_4000, 32'hCAFE_F00D, 2'b10);
    step();
    idle_req();
    chk("err.pulse_end", {31'b0, err_size}, 32'd0);
    chk_beat("sw0", 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
    step();
    chk_done("sw0");
    chk("sw0.no_err", {31'b0, err_size}, 32'd0);
    step();

    // reset in the middle of a split store
    send(32'h0000_5001, 32'hA1B2_C3D4, 2'b10);
    step();
    idle_req();
    chk_beat("swrst.b0", 32'h0000_5000, 32'hB2C3_D400, 4'b1110);
    step();
    chk_beat("swrst.b1", 32'h0000_5004, 32'h0000_00A1, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("swrst.valid_drop", {31'b0, mem_valid}, 32'd0);
    chk("swrst.addr_clear", mem_addr, 32'd0);
    chk("swrst.wstrb_clear", {28'b0, mem_wstrb}, 32'd0);
    chk("swrst.no_done", {31'b0, done}, 32'd0);
    step();
    chk("swrst.held_no_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("swrst.ready", {31'b0, req_ready}, 32'd1);
    chk("swrst.still_idle", {31'b0, mem_valid}, 32'd0);
    chk("swrst.no_done_after", {31'b0, done}, 32'd0);
    send(32'h0000_6001, 32'h7777_77C3, 2'b00);
    step();
    idle_req();
    chk_beat("sbpost", 32'h0000_6000, 32'h0000_C300, 4'b0010);
    step();
    chk_done("sbpost");
    step();
    chk("sbpost.done_clear", {31'b0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_lane_packer.md
Name: store_lane_packer

Overview:
Store-side counterpart to the load-path byte/half sign extenders. Takes an SB/SH/SW store request (byte address, 32-bit register data, size) and packs the narrow value into the correct byte lanes of a word-aligned memory write with byte strobes. Stores that cross a word boundary (misaligned SH/SW) are split into two sequential memory beats. Sits between the execute stage's store request and the data-memory write port, with valid/ready handshakes on both sides.

Parameters:
None. All widths are fixed: 32-bit address, 32-bit data, 4-bit strobe.

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  store request valid
req_ready  output  1  unit can accept a request (high only in IDLE)
req_addr  input  32  byte address
req_data  input  32  store data; only low 8/16 bits are used for SB/SH
req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
mem_valid  output  1  memory write beat valid
mem_ready  input  1  memory accepts beat
mem_addr  output  32  word-aligned write address (bits[1:0]=00)
mem_wdata  output  32  lane-packed write data; unstrobed lanes are 0
mem_wstrb  output  4  byte strobes; bit i enables lane i (bits 8i+7:8i)
done  output  1  one-cycle pulse: store fully written
err_size  output  1  one-cycle pulse: illegal size request dropped

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_valid=0, done=0, err_size=0; mem_addr/mem_wdata/mem_wstrb=0. An in-flight store is abandoned, and no further beat is issued.
- States: IDLE, BEAT0, BEAT1. req_ready = (state==IDLE).
- Accept when req_valid & req_ready. At acceptance, the unit registers:
  - off = req_addr[1:0]; base = {req_addr[31:2],2'b00}.
  - masked data: byte -> {24'b0,data[7:0]}; half -> {16'b0,data[15:0]}; word -> data.
  - 64-bit wide = {32'b0,masked} << (8*off); 8-bit strb = basemask << off, where basemask is 0001/0011/1111 for byte/half/word.
- IDLE, legal size accepted: go to BEAT0. mem_valid rises the next cycle (1-cycle latency). mem_addr=base, mem_wdata=wide[31:0], mem_wstrb=strb[3:0].
- IDLE, size=11 accepted: stay IDLE. err_size pulses the next cycle. No memory beat is issued.
- BEAT0 with mem_valid & mem_ready:
  - If strb[7:4]!=0, go to BEAT1: mem_addr=base+4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), mem_wdata=wide[63:32], mem_wstrb=strb[7:4]. mem_valid stays high with no bubble.
  - Otherwise go to IDLE: mem_valid=0, done=1 for one cycle.
- BEAT1 with mem_valid & mem_ready: go to IDLE, mem_valid=0, done=1 for one cycle.
- Backpressure: while mem_valid=1 and mem_ready=0, mem_addr/wdata/wstrb/mem_valid hold stable.
- Aligned stores (byte at any offset, half at off 0..2, word at off 0) always take one beat. Half at off 3 and word at off 1..3 take two beats.
- Throughput: a new request can be accepted in the cycle done is high (state is IDLE). Minimum period is 2 cycles per single-beat store and 3 cycles per split store.
- req_* is sampled only at acceptance; changes afterwards have no effect.
- All outputs are registered; there is no combinational path from req_* or mem_ready to mem_* outputs.

Test Plan:
- SB addr=0x00001003 data=0x123456AB -> one beat: mem_addr=0x00001000, wdata=0xAB000000, wstrb=1000; done pulses 1 cycle after handshake.
- SH addr=0x00002003 data=0xFFFFBEEF -> beat0: 0x00002000/0xEF000000/1000. beat1: 0x00002004/0x000000BE/0001. One done pulse, after beat1.
- SW addr=0x00003002 data=0xDEADBEEF, mem_ready held low 3 cycles on beat0 -> beat0 0x00003000/0xBEEF0000/1100 stays stable for 4 cycles. Then beat1 0x00003004/0x0000DEAD/0011.
- SW addr=0xFFFFFFFD data=0x11223344 -> beat0 0xFFFFFFFC/0x22334400/1110. beat1 wraps: 0x00000000/0x00000011/0001.
- size=11 addr=0x4000 -> no mem_valid; err_size pulses once. A back-to-back SW addr=0x4000 data=0xCAFEF00D is accepted the next cycle -> 0x00004000/0xCAFEF00D/1111.
- SW addr=0x5001, reset_n driven low during BEAT1 -> mem_valid=0 immediately and no done. After release, req_ready=1 and a new SB completes normally.
